// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, control codes and state encoding for the multi-cycle CPU
package cpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_J    = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic       iorD;
        logic       aluSrc;
        logic [2:0] aluOp;
        logic       memToReg;
        logic       regWrite;
        logic [1:0] pcSrc;
        logic       halted;
    } ctrl_t;

    function automatic logic isLegal(input logic [3:0] o);
        return (o <= OP_J) || (o == OP_HALT);
    endfunction

    // Registered control levels for a state; handshake-qualified strobes are handled in the top.
    function automatic ctrl_t stateCtrl(input state_t s, input logic [3:0] o);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memRead = 1'b1;
                c.pcSrc   = PC_INC;
            end
            S_EXEC: begin
                case (o)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: c.aluOp = o[2:0];
                    OP_ADDI, OP_LW, OP_SW: begin
                        c.aluOp  = ALU_ADD;
                        c.aluSrc = 1'b1;
                    end
                    OP_BEQ: begin
                        c.aluOp = ALU_SUB;
                        c.pcSrc = PC_BRANCH;
                    end
                    OP_J:    c.pcSrc = PC_JUMP;
                    default: c.aluOp = ALU_ADD;
                endcase
            end
            S_MEM: begin
                c.iorD     = 1'b1;
                c.memRead  = (o == OP_LW);
                c.memWrite = (o == OP_SW);
            end
            S_WB: begin
                c.regWrite = 1'b1;
                c.memToReg = (o == OP_LW);
            end
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_mc_timeout.sv
// rtl/cpu_mc_timeout.sv - memory wait counter that flags a bus timeout
module cpu_mc_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/cpu_mc_ctrl.sv
// rtl/cpu_mc_ctrl.sv - multi-cycle control sequencer for the 16-bit CPU datapath
module cpu_mc_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             run,
    input  logic [3:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             ALUSrc,
    output logic [2:0]       ALUOp,
    output logic             MemToReg,
    output logic [1:0]       PCSrc,
    output logic             halted,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] retired
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t     state;
    logic [3:0] opReg;
    ctrl_t      ctl;
    logic [1:0] errReg;
    logic       inMem;
    logic       expired;

    function automatic state_t afterRetire(input logic r);
        return r ? S_FETCH : S_IDLE;
    endfunction

    assign inMem = (state == S_FETCH) || (state == S_MEM);

    // Counter restarts whenever no access is outstanding, so every FETCH/MEM entry starts from zero.
    cpu_mc_timeout #(.TIMEOUT(TIMEOUT)) uTimeout (
        .clk    (CLK),
        .reset  (RESET),
        .clear  (!inMem || mem_ready),
        .enable (inMem && !mem_ready),
        .expired(expired)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            opReg   <= OP_ADD;
            ctl     <= '0;
            errReg  <= ERR_NONE;
            retired <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                        ctl   <= stateCtrl(S_FETCH, opReg);
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        state <= S_DECODE;
                        ctl   <= stateCtrl(S_DECODE, opReg);
                    end else if (expired) begin
                        state  <= S_HALT;
                        ctl    <= stateCtrl(S_HALT, opReg);
                        errReg <= ERR_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    opReg <= op;
                    if (!isLegal(op)) begin
                        state  <= S_HALT;
                        ctl    <= stateCtrl(S_HALT, op);
                        errReg <= ERR_ILLEGAL;
                    end else if (op == OP_HALT) begin
                        state   <= S_HALT;
                        ctl     <= stateCtrl(S_HALT, op);
                        retired <= retired + CNT_ONE;
                    end else begin
                        state <= S_EXEC;
                        ctl   <= stateCtrl(S_EXEC, op);
                    end
                end
                S_EXEC: begin
                    case (opReg)
                        OP_BEQ, OP_J: begin
                            state   <= afterRetire(run);
                            ctl     <= stateCtrl(afterRetire(run), opReg);
                            retired <= retired + CNT_ONE;
                        end
                        OP_LW, OP_SW: begin
                            state <= S_MEM;
                            ctl   <= stateCtrl(S_MEM, opReg);
                        end
                        default: begin
                            state <= S_WB;
                            ctl   <= stateCtrl(S_WB, opReg);
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (opReg == OP_LW) begin
                            state <= S_WB;
                            ctl   <= stateCtrl(S_WB, opReg);
                        end else begin
                            state   <= afterRetire(run);
                            ctl     <= stateCtrl(afterRetire(run), opReg);
                            retired <= retired + CNT_ONE;
                        end
                    end else if (expired) begin
                        state  <= S_HALT;
                        ctl    <= stateCtrl(S_HALT, opReg);
                        errReg <= ERR_TIMEOUT;
                    end
                end
                S_WB: begin
                    state   <= afterRetire(run);
                    ctl     <= stateCtrl(afterRetire(run), opReg);
                    retired <= retired + CNT_ONE;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                    ctl   <= '0;
                end
            endcase
        end
    end

    // Write strobes qualified by mem_ready/zero must act in the same cycle as the handshake.
    assign IRWrite = (state == S_FETCH) && mem_ready;
    assign PCWrite = ((state == S_FETCH) && mem_ready) ||
                     ((state == S_EXEC) && ((opReg == OP_J) || ((opReg == OP_BEQ) && zero)));

    assign RegWrite = ctl.regWrite;
    assign MemRead  = ctl.memRead;
    assign MemWrite = ctl.memWrite;
    assign IorD     = ctl.iorD;
    assign ALUSrc   = ctl.aluSrc;
    assign ALUOp    = ctl.aluOp;
    assign MemToReg = ctl.memToReg;
    assign PCSrc    = ctl.pcSrc;
    assign halted   = ctl.halted;
    assign err      = errReg;

endmodule

// File: tb/tb_cpu_mc_ctrl.sv
// tb/tb_cpu_mc_ctrl.sv - scoreboard bench for the multi-cycle control sequencer
module tb_cpu_mc_ctrl;

    localparam int TO = 15;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  op = 4'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, ALUSrc, MemToReg, halted;
    logic [2:0]  ALUOp;
    logic [1:0]  PCSrc, err;
    logic [15:0] retired;

    logic        pReset = 1'b1;
    logic        pRun = 1'b0;
    logic [3:0]  pOp = 4'h0;
    logic [15:0] expRet = 16'd0;
    int          nChecks = 0;
    int          nPass = 0;

    logic [31:0] expQ[$];
    string       tagQ[$];
    logic [31:0] obs;

    cpu_mc_ctrl #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .run(run), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .IorD(IorD), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemToReg(MemToReg),
        .PCSrc(PCSrc), .halted(halted), .err(err), .retired(retired)
    );

    always #5 CLK = ~CLK;

    assign obs = {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, ALUSrc, ALUOp,
                  MemToReg, PCSrc, halted, err, retired};

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            nPass++;
    endtask

    always @(negedge CLK) begin
        if (expQ.size() > 0) checkVal(tagQ.pop_front(), obs, expQ.pop_front());
    end

    function automatic logic [31:0] ex(input logic pcw, input logic irw, input logic rw,
                                       input logic mr, input logic mw, input logic iord,
                                       input logic as, input logic [2:0] aop, input logic m2r,
                                       input logic [1:0] pcs, input logic h, input logic [1:0] e);
        return {pcw, irw, rw, mr, mw, iord, as, aop, m2r, pcs, h, e, expRet};
    endfunction

    function automatic logic [31:0] zeroEx();
        return ex(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0);
    endfunction

    task automatic cycSkip();
        @(posedge CLK); #1;
        RESET = pReset; run = pRun; op = pOp; mem_ready = 1'b0; zero = 1'b0;
    endtask

    task automatic cyc(input logic mr, input logic z, input logic [31:0] exp, input string tag);
        @(posedge CLK); #1;
        RESET = pReset; run = pRun; op = pOp; mem_ready = mr; zero = z;
        expQ.push_back(exp);
        tagQ.push_back(tag);
    endtask

    task automatic doReset();
        pReset = 1'b1; pRun = 1'b1;
        cycSkip();
        expRet = 16'd0;
        cyc(1'b0, 1'b0, zeroEx(), "resetHold");
        pReset = 1'b0;
        cyc(1'b1, 1'b1, zeroEx(), "idleAfterReset");
    endtask

    // Inputs that could wake the datapath are driven high to show HALT ignores them.
    task automatic haltCycles(input int n, input logic [1:0] e);
        for (int i = 0; i < n; i++)
            cyc(1'b1, 1'b1, ex(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 1, e), "halt");
    endtask

    task automatic retire(input logic runEnd);
        expRet++;
        if (!runEnd) begin
            pRun = 1'b1;
            cyc(1'b0, 1'b0, zeroEx(), "idleReturn");
        end
    endtask

    // fw/mw: cycles with mem_ready low before the access completes in FETCH/MEM.
    task automatic instr(input logic [3:0] o, input int fw, input int mw, input logic z,
                         input logic runEnd);
        pOp = o; pRun = 1'b1;
        for (int i = 0; i < fw; i++) begin
            cyc(1'b0, 1'b0, ex(0, 0, 0, 1, 0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0), "fetchWait");
            if (i == TO) begin haltCycles(3, 2'b10); return; end
        end
        cyc(1'b1, 1'b0, ex(1, 1, 0, 1, 0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0), "fetch");
        cyc(1'b0, 1'b0, zeroEx(), "decode");
        if (o >= 4'h9 && o <= 4'hE) begin haltCycles(20, 2'b01); return; end
        if (o == 4'hF) begin expRet++; haltCycles(3, 2'b00); return; end
        case (o)
            4'h0, 4'h1, 4'h2, 4'h3:
                cyc(1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, o[2:0], 0, 2'd0, 0, 2'd0), "execR");
            4'h4, 4'h5, 4'h6:
                cyc(1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 1, 3'd0, 0, 2'd0, 0, 2'd0), "execImm");
            4'h7: begin
                pRun = runEnd;
                cyc(1'b0, z, ex(z, 0, 0, 0, 0, 0, 0, 3'd1, 0, 2'd1, 0, 2'd0), "execBeq");
                retire(runEnd);
                return;
            end
            default: begin
                pRun = runEnd;
                cyc(1'b0, 1'b0, ex(1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 2'd2, 0, 2'd0), "execJ");
                retire(runEnd);
                return;
            end
        endcase
        if (o == 4'h5 || o == 4'h6) begin
            for (int i = 0; i < mw; i++) begin
                cyc(1'b0, 1'b0, ex(0, 0, 0, o == 4'h5, o == 4'h6, 1, 0, 3'd0, 0, 2'd0, 0, 2'd0),
                    "memWait");
                if (i == TO) begin haltCycles(3, 2'b10); return; end
            end
            if (o == 4'h6) begin
                pRun = runEnd;
                cyc(1'b1, 1'b0, ex(0, 0, 0, 0, 1, 1, 0, 3'd0, 0, 2'd0, 0, 2'd0), "memSw");
                retire(runEnd);
                return;
            end
            cyc(1'b1, 1'b0, ex(0, 0, 0, 1, 0, 1, 0, 3'd0, 0, 2'd0, 0, 2'd0), "memLw");
        end
        pRun = runEnd;
        cyc(1'b0, 1'b0, ex(0, 0, 1, 0, 0, 0, 0, 3'd0, o == 4'h5, 2'd0, 0, 2'd0), "wb");
        retire(runEnd);
    endtask

    initial begin
        doReset();
        for (int k = 0; k < 5; k++) instr(4'(k), 0, 0, 1'b0, 1'b1);
        instr(4'h5, 0, 3, 1'b0, 1'b1);
        instr(4'h6, 2, 0, 1'b0, 1'b1);
        instr(4'h7, 0, 0, 1'b1, 1'b1);
        instr(4'h7, 0, 0, 1'b0, 1'b1);
        instr(4'h8, 0, 0, 1'b1, 1'b1);
        instr(4'h0, 0, 0, 1'b0, 1'b0);
        instr(4'h8, 0, 0, 1'b0, 1'b0);
        instr(4'h6, 0, 1, 1'b0, 1'b0);
        instr(4'h3, TO, 0, 1'b0, 1'b1);
        instr(4'h5, 0, TO, 1'b0, 1'b1);
        instr(4'hF, 0, 0, 1'b0, 1'b1);

        doReset();
        instr(4'h0, TO + 1, 0, 1'b0, 1'b1);

        doReset();
        instr(4'hB, 0, 0, 1'b0, 1'b1);

        doReset();
        instr(4'h5, 0, TO + 1, 1'b0, 1'b1);

        doReset();
        pOp = 4'h6;
        cyc(1'b1, 1'b0, ex(1, 1, 0, 1, 0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0), "swFetch");
        cyc(1'b0, 1'b0, zeroEx(), "swDecode");
        cyc(1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 1, 3'd0, 0, 2'd0, 0, 2'd0), "swExec");
        cyc(1'b0, 1'b0, ex(0, 0, 0, 0, 1, 1, 0, 3'd0, 0, 2'd0, 0, 2'd0), "swWait");
        pReset = 1'b1;
        cyc(1'b0, 1'b0, ex(0, 0, 0, 0, 1, 1, 0, 3'd0, 0, 2'd0, 0, 2'd0), "swWaitRst");
        pReset = 1'b0; pRun = 1'b0;
        cyc(1'b1, 1'b0, zeroEx(), "swAfterRst");
        cyc(1'b1, 1'b0, zeroEx(), "idleHold");

        @(posedge CLK); #1;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
